// File: rtl/control_multiciclo_if.sv
// control_multiciclo_if: instruction fields and control outputs between the control unit and the multicycle datapath
interface control_multiciclo_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic       RegWrite;
  logic [3:0] Flags;
  logic [3:0] State;
  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, Flags, State
  );
  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc, RegWrite, Flags, State
  );
endinterface

// File: rtl/control_multiciclo.sv
// control_multiciclo: multicycle ARMv4 control unit (Moore FSM, ALU decoder, condition check, NZCV flags)
module control_multiciclo (
  input logic clk,
  input logic rst_n,
  control_multiciclo_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;
  state_t state, next;
  logic next_pc, br, reg_w, mem_w, alu_op, ir_w, cond_ex, cond_ex_r, pcs, s;
  logic adr_src, alu_src_a;
  logic [1:0] result_src, alu_src_b, flag_w;
  logic [3:0] cmd, flags;
  logic n, z, c, v;
  assign cmd = bus.Funct[4:1];
  assign s = bus.Funct[0];
  assign {n, z, c, v} = flags;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      flags <= '0;
      cond_ex_r <= 1'b0;
    end else begin
      state <= next;
      if (state == DECODE) cond_ex_r <= cond_ex;
      if ((state == EXECUTER || state == EXECUTEI) && cond_ex_r) begin
        if (flag_w[1]) flags[3:2] <= bus.ALUFlags[3:2];
        if (flag_w[0]) flags[1:0] <= bus.ALUFlags[1:0];
      end
    end
  always_comb begin
    next = FETCH;
    ir_w = 1'b0;
    next_pc = 1'b0;
    br = 1'b0;
    reg_w = 1'b0;
    mem_w = 1'b0;
    alu_op = 1'b0;
    adr_src = 1'b0;
    alu_src_a = 1'b0;
    result_src = 2'b00;
    alu_src_b = 2'b00;
    case (state)
      FETCH: begin
        ir_w = 1'b1;
        next_pc = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
        next = DECODE;
      end
      DECODE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
        next = bus.Op == 2'b01 ? MEMADR : bus.Op == 2'b10 ? BRANCH :
               bus.Op == 2'b11 ? FETCH : bus.Funct[5] ? EXECUTEI : EXECUTER;
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        next = s ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        next = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w = 1'b1;
      end
      EXECUTER: begin
        alu_op = 1'b1;
        next = ALUWB;
      end
      EXECUTEI: begin
        alu_src_b = 2'b01;
        alu_op = 1'b1;
        next = ALUWB;
      end
      ALUWB: reg_w = cmd != 4'b1010;
      BRANCH: begin
        alu_src_b = 2'b01;
        result_src = 2'b10;
        br = 1'b1;
      end
      default: next = FETCH;
    endcase
  end
  always_comb begin
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = !c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = c && !z;
      4'b1001: cond_ex = !c || z;
      4'b1010: cond_ex = n == v;
      4'b1011: cond_ex = n != v;
      4'b1100: cond_ex = !z && (n == v);
      4'b1101: cond_ex = z || (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  // CMP writes flags like SUB but never the register file; unknown cmds fall back to ADD without flags
  assign flag_w[1] = alu_op && s && (cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010});
  assign flag_w[0] = alu_op && s && (cmd inside {4'b0100, 4'b0010, 4'b1010});
  assign bus.ALUControl = !alu_op ? 4'b0000 :
                          (cmd == 4'b0010 || cmd == 4'b1010) ? 4'b0001 :
                          cmd == 4'b0000 ? 4'b0010 :
                          cmd == 4'b1100 ? 4'b0011 : 4'b0000;
  assign pcs = br || (reg_w && bus.Rd == 4'd15);
  assign bus.PCWrite = rst_n && (next_pc || (pcs && cond_ex_r));
  assign bus.RegWrite = rst_n && reg_w && cond_ex_r && bus.Rd != 4'd15;
  assign bus.MemWrite = rst_n && mem_w && cond_ex_r;
  assign bus.IRWrite = rst_n && ir_w;
  assign bus.AdrSrc = adr_src;
  assign bus.ResultSrc = result_src;
  assign bus.ALUSrcA = alu_src_a;
  assign bus.ALUSrcB = alu_src_b;
  assign bus.ImmSrc = bus.Op;
  assign bus.RegSrc = {bus.Op == 2'b01, bus.Op == 2'b10};
  assign bus.Flags = flags;
  assign bus.State = state;
endmodule
